lcd_nibble_reader: RTL and testbench

HD44780-style 4-bit read engine for the character LCD on the SF_D[11:8] bus. Everything else in the design only writes to the LCD. This block performs the read direction (LCD_RW=1): two E strobes sample the high nibble and then the low nibble, and the byte is returned to the CPU/LCD writer. The read can target the busy-flag/address register (RS=0) or display RAM data (RS=1). The top level multiplexes LCD_E, LCD_RS and LCD_RW between this block and the LCD writer, and tristates the writer's SF_D drive while rd_active=1.

---
 rtl/lcd_nibble_reader.sv | 147 ++++++++++++++
 tb/tb_lcd_nibble_reader.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/lcd_nibble_reader.sv
// HD44780 4-bit read engine: two E strobes capture the high then low nibble of SF_D[11:8].
// Optional macro LCD_BUSY_POLL_EN adds busy-flag polling (poll input, timeout output).
module lcd_nibble_reader #(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned E_HIGH_CYC = 20,
  parameter int unsigned E_LOW_CYC  = 50,
  parameter int unsigned POLL_LIMIT = 255
) (
  input  logic       inCLK_50MHZ,
  input  logic       BTN_NORTH,
  input  logic       req,
  input  logic       rs_sel,
`ifdef LCD_BUSY_POLL_EN
  input  logic       poll,
  output logic       timeout,
`endif
  input  logic [3:0] SF_D_in,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       rd_active,
  output logic       busy,
  output logic       valid,
  output logic [7:0] rdata
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] EHI1  = 3'd2;
  localparam logic [2:0] ELO1  = 3'd3;
  localparam logic [2:0] EHI2  = 3'd4;
  localparam logic [2:0] ELO2  = 3'd5;
  localparam logic [2:0] DONE  = 3'd6;

  localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
  localparam logic [7:0] EHI_LD   = 8'(E_HIGH_CYC - 1);
  localparam logic [7:0] ELO_LD   = 8'(E_LOW_CYC - 1);
  localparam logic [8:0] POLL_MAX = 9'(POLL_LIMIT);

  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] reads_q, reads_d;
  logic       rs_q, rs_d;
  logic       poll_q, poll_d;
  logic [3:0] hi_q, hi_d;
  logic [3:0] lo_q, lo_d;
  logic       poll_w;
  logic       in_xfer;

`ifdef LCD_BUSY_POLL_EN
  assign poll_w = poll;
`else
  assign poll_w = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    reads_d = reads_q;
    rs_d    = rs_q;
    poll_d  = poll_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: if (req) begin
        state_d = SETUP;
        cnt_d   = SETUP_LD;
        rs_d    = rs_sel;
        poll_d  = poll_w;
        reads_d = 8'd0;
      end
      SETUP: if (cnt_q == 8'd0) begin
        state_d = EHI1;
        cnt_d   = EHI_LD;
      end else cnt_d = cnt_q - 8'd1;
      EHI1: if (cnt_q == 8'd0) begin
        hi_d    = SF_D_in;
        state_d = ELO1;
        cnt_d   = ELO_LD;
      end else cnt_d = cnt_q - 8'd1;
      ELO1: if (cnt_q == 8'd0) begin
        state_d = EHI2;
        cnt_d   = EHI_LD;
      end else cnt_d = cnt_q - 8'd1;
      EHI2: if (cnt_q == 8'd0) begin
        lo_d    = SF_D_in;
        state_d = ELO2;
        cnt_d   = ELO_LD;
      end else cnt_d = cnt_q - 8'd1;
      ELO2: if (cnt_q == 8'd0) begin
        // Busy flag still set on a polled status read: go round again until the read budget is spent.
        if (poll_q && !rs_q && hi_q[3] && (({1'b0, reads_q} + 9'd1) < POLL_MAX)) begin
          state_d = SETUP;
          cnt_d   = SETUP_LD;
          reads_d = reads_q + 8'd1;
        end else state_d = DONE;
      end else cnt_d = cnt_q - 8'd1;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  assign in_xfer = (state_d == SETUP) || (state_d == EHI1) || (state_d == ELO1) ||
                   (state_d == EHI2)  || (state_d == ELO2);

  always_ff @(posedge inCLK_50MHZ) begin
    if (BTN_NORTH) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      reads_q   <= 8'd0;
      rs_q      <= 1'b0;
      poll_q    <= 1'b0;
      LCD_E     <= 1'b0;
      LCD_RS    <= 1'b0;
      LCD_RW    <= 1'b0;
      rd_active <= 1'b0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      rdata     <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      reads_q   <= reads_d;
      rs_q      <= rs_d;
      poll_q    <= poll_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      LCD_E     <= (state_d == EHI1) || (state_d == EHI2);
      LCD_RS    <= in_xfer & rs_d;
      LCD_RW    <= in_xfer;
      rd_active <= in_xfer;
      busy      <= (state_d != IDLE);
      valid     <= (state_d == DONE);
      if (state_d == DONE) rdata <= {hi_q, lo_q};
    end
  end

`ifdef LCD_BUSY_POLL_EN
  // Reaching DONE with the busy flag still set on a polled status read means the budget ran out.
  always_ff @(posedge inCLK_50MHZ) begin
    if (BTN_NORTH) timeout <= 1'b0;
    else if (state_d == DONE) timeout <= poll_q & ~rs_q & hi_q[3];
  end
`endif

endmodule

// File: tb/tb_lcd_nibble_reader.sv
// Directed self-checking bench for lcd_nibble_reader (default timing: valid 143 cycles after accept).
`timescale 1ns/1ps
module tb_lcd_nibble_reader;

`ifdef LCD_BUSY_POLL_EN
  localparam int TB_PL = 4;
`else
  localparam int TB_PL = 255;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic       rs_sel;
  logic [3:0] sf_d;
  logic       lcd_e, lcd_rs, lcd_rw, rd_active, busy, valid;
  logic [7:0] rdata;
`ifdef LCD_BUSY_POLL_EN
  logic       poll;
  logic       timeout;
`endif

  int checks = 0;
  int failures = 0;

  always #10 clk = ~clk;

  lcd_nibble_reader #(
    .SETUP_CYC(2), .E_HIGH_CYC(20), .E_LOW_CYC(50), .POLL_LIMIT(TB_PL)
  ) dut (
    .inCLK_50MHZ(clk),
    .BTN_NORTH  (rst),
    .req        (req),
    .rs_sel     (rs_sel),
`ifdef LCD_BUSY_POLL_EN
    .poll       (poll),
    .timeout    (timeout),
`endif
    .SF_D_in    (sf_d),
    .LCD_E      (lcd_e),
    .LCD_RS     (lcd_rs),
    .LCD_RW     (lcd_rw),
    .rd_active  (rd_active),
    .busy       (busy),
    .valid      (valid),
    .rdata      (rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One read accepted at edge k; loop index n is cycle k+n. Bus carries hi only in
  // EHI1 (n=3..22), lo only in EHI2 (n=73..92), and 4'hF everywhere else.
  task automatic run_read(input string nm, input logic rs, input logic [3:0] hi,
                          input logic [3:0] lo, input logic mid_req, input logic [7:0] exp);
    int e_bad = 0, ctl_bad = 0, idle_bad = 0, vcnt = 0, vpos = -1;
    rs_sel = rs; req = 1'b1; sf_d = 4'hF;
    tick();
    req = 1'b0; rs_sel = ~rs;
    for (int n = 1; n <= 150; n++) begin
      sf_d = (n >= 3 && n <= 22) ? hi : (n >= 73 && n <= 92) ? lo : 4'hF;
      req  = mid_req && (n == 50 || n == 143);
      if (lcd_e !== ((n >= 3 && n <= 22) || (n >= 73 && n <= 92))) e_bad++;
      if (n <= 142 && (lcd_rw !== 1'b1 || rd_active !== 1'b1 || busy !== 1'b1 ||
                       lcd_rs !== rs || valid !== 1'b0)) ctl_bad++;
      if (valid === 1'b1) begin vcnt++; vpos = n; end
      if (n == 143) begin
        check({nm, "_rdata"}, rdata, exp);
        check({nm, "_done_ctl"}, {lcd_rw, lcd_rs, rd_active, lcd_e, busy}, 5'b00001);
      end
      if (n >= 144 && (busy !== 1'b0 || lcd_rw !== 1'b0 || lcd_e !== 1'b0)) idle_bad++;
      tick();
    end
    req = 1'b0;
    check({nm, "_e_pattern"}, e_bad, 0);
    check({nm, "_ctl"}, ctl_bad, 0);
    check({nm, "_valid_cnt"}, vcnt, 1);
    check({nm, "_valid_pos"}, vpos, 143);
    check({nm, "_idle_after"}, idle_bad, 0);
    check({nm, "_rdata_hold"}, rdata, exp);
  endtask

`ifdef LCD_BUSY_POLL_EN
  task automatic poll_run(input string nm, input int nbf1, input int exp_reads,
                          input logic exp_to, input logic [7:0] exp_rd);
    int rises = 0, vcnt = 0, rd;
    logic prev_e = 1'b0;
    logic to_seen = 1'b0;
    logic [7:0] rd_seen = 8'd0;
    poll = 1'b1; rs_sel = 1'b0; req = 1'b1; sf_d = 4'h0;
    tick();
    req = 1'b0; poll = 1'b0;
    for (int n = 1; n <= 2000; n++) begin
      if (lcd_e && !prev_e) rises++;
      prev_e = lcd_e;
      rd = (rises + 1) / 2;
      if (lcd_e) sf_d = (rises % 2 == 1) ? ((rd <= nbf1) ? 4'h8 : 4'h0) : 4'h1;
      if (valid === 1'b1) begin
        vcnt++; to_seen = timeout; rd_seen = rdata;
        break;
      end
      tick();
    end
    tick();
    check({nm, "_e_strobes"}, rises, 2 * exp_reads);
    check({nm, "_valid"}, vcnt, 1);
    check({nm, "_timeout"}, to_seen, exp_to);
    check({nm, "_rdata"}, rd_seen, exp_rd);
  endtask
`endif

  initial begin
    int v1 = -1, v2 = -1, vcnt = 0;
    logic gap_busy = 1'b1;
    rst = 1'b1; req = 1'b0; rs_sel = 1'b0; sf_d = 4'h0;
`ifdef LCD_BUSY_POLL_EN
    poll = 1'b0;
`endif
    repeat (3) tick();
    rst = 1'b0;
    repeat (10) tick();
    check("reset_outputs", {lcd_e, lcd_rs, lcd_rw, rd_active, busy, valid}, 6'b0);
    check("reset_rdata", rdata, 8'h00);

    run_read("data_a5", 1'b1, 4'hA, 4'h5, 1'b0, 8'hA5);
    run_read("status_3c", 1'b0, 4'h3, 4'hC, 1'b0, 8'h3C);
    run_read("midreq_96", 1'b1, 4'h9, 4'h6, 1'b1, 8'h96);

    // req held high: back-to-back transactions with a one-cycle IDLE gap.
    rs_sel = 1'b1; sf_d = 4'h6; req = 1'b1;
    tick();
    for (int n = 1; n <= 400; n++) begin
      if (valid === 1'b1) begin
        if (v1 < 0) v1 = n;
        else begin v2 = n; break; end
      end
      if (v1 > 0 && n == v1 + 1) gap_busy = busy;
      tick();
    end
    req = 1'b0;
    repeat (3) tick();
    check("held_first_valid", v1, 143);
    check("held_spacing", v2 - v1, 144);
    check("held_gap_busy", gap_busy, 1'b0);
    check("held_rdata", rdata, 8'h66);

    // Reset pulse in the middle of EHI2 aborts the read.
    rs_sel = 1'b0; req = 1'b1;
    tick();
    req = 1'b0;
    repeat (79) tick();
    check("abort_in_ehi2", lcd_e, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_ctl", {lcd_e, lcd_rw, rd_active, busy, valid, lcd_rs}, 6'b0);
    check("abort_rdata", rdata, 8'h00);
    for (int n = 0; n < 200; n++) begin
      if (valid === 1'b1 || busy === 1'b1) vcnt++;
      tick();
    end
    check("abort_quiet", vcnt, 0);
    run_read("after_abort", 1'b1, 4'h2, 4'hD, 1'b0, 8'h2D);

`ifdef LCD_BUSY_POLL_EN
    poll_run("poll_bf2", 2, 3, 1'b0, 8'h01);
    poll_run("poll_stuck", 99, 4, 1'b1, 8'h81);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
